// File: rtl/router_pkg.sv
// Shared router definitions: reader FSM states and the header byte field layout
// (addr in the low bits, payload length above it).
package router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PLD  = 2'd2,
        PAR  = 2'd3
    } rd_state_e;

    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = 2;
    localparam int LEN_LSB  = 2;
    localparam int LEN_W    = 6;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
        return hdr[LEN_LSB +: LEN_W];
    endfunction

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry output buffer between the packet parser and the downstream byte
// stream; the head entry stays put while the consumer stalls.
module router_skid_buf (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       last_o,
    input  logic       ready_i,
    output logic [1:0] count_o
);

    logic [1:0][7:0] data_q;
    logic [1:0]      last_q;
    logic            rd_q;
    logic            wr_q;
    logic [1:0]      cnt_q;
    logic            pop;

    assign valid_o = (cnt_q != 2'd0);
    assign pop     = valid_o & ready_i;
    assign data_o  = data_q[rd_q];
    assign last_o  = last_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            last_q <= '0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            cnt_q  <= 2'd0;
        end else if (flush_i) begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) begin
                data_q[wr_q] <= data_i;
                last_q[wr_q] <= last_i;
                wr_q         <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/router_out_reader.sv
// Output-port reader: drains the port FIFO, parses header/payload/parity packets
// and streams header+payload downstream. Parity checking is built with READER_PARITY_CHK_EN.
module router_out_reader
    import router_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid_out,
    input  logic             soft_reset,
    input  logic [7:0]       data_out,
    output logic             read_en,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             pkt_done,
    output logic             parity_err,
    output logic             pkt_abort,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    rd_state_e        state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             inflight_q;
    logic             pkt_done_q, pkt_abort_q;
    logic [CNT_W-1:0] pkt_count_q;
    logic             push, push_last, done_d, abort;
    logic [1:0]       buf_cnt;
    logic [2:0]       occ;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Bytes the reader already owns: buffered (net of this cycle's transfer) plus the one in flight.
    assign occ     = {1'b0, buf_cnt} - {2'b0, m_valid & m_ready} + {2'b0, inflight_q};
    assign read_en = resetn & valid_out & ~soft_reset & (occ < 3'd2);
    assign abort   = soft_reset & (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        push      = 1'b0;
        push_last = 1'b0;
        done_d    = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (read_en) state_d = HDR;
                HDR: if (inflight_q) begin
                    push  = 1'b1;
                    rem_d = hdr_len(data_out);
                    if (hdr_len(data_out) == '0) begin
                        push_last = 1'b1;
                        state_d   = PAR;
                    end else begin
                        state_d = PLD;
                    end
                end
                PLD: if (inflight_q) begin
                    push  = 1'b1;
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        push_last = 1'b1;
                        state_d   = PAR;
                    end
                end
                PAR: if (inflight_q) begin
                    done_d  = 1'b1;
                    state_d = read_en ? HDR : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            inflight_q  <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_abort_q <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            inflight_q  <= read_en;
            pkt_done_q  <= done_d;
            pkt_abort_q <= abort;
            if (done_d) begin
                pkt_count_q <= sat_inc(pkt_count_q);
            end
        end
    end

    assign pkt_done  = pkt_done_q;
    assign pkt_abort = pkt_abort_q;
    assign pkt_count = pkt_count_q;

`ifdef READER_PARITY_CHK_EN
    logic [7:0]       acc_q, acc_d;
    logic             parity_err_q;
    logic [CNT_W-1:0] err_count_q;
    logic             err_d;

    always_comb begin
        acc_d = acc_q;
        if (inflight_q && state_q == HDR) begin
            acc_d = data_out;
        end else if (inflight_q && state_q == PLD) begin
            acc_d = acc_q ^ data_out;
        end
    end

    assign err_d = done_d & (acc_q != data_out);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q        <= 8'h00;
            parity_err_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            acc_q        <= acc_d;
            parity_err_q <= err_d;
            if (err_d) begin
                err_count_q <= sat_inc(err_count_q);
            end
        end
    end

    assign parity_err = parity_err_q;
    assign err_count  = err_count_q;
`else
    assign parity_err = 1'b0;
    assign err_count  = '0;
`endif

    router_skid_buf u_skid (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .flush_i (abort),
        .push_i  (push),
        .data_i  (data_out),
        .last_i  (push_last),
        .valid_o (m_valid),
        .data_o  (m_data),
        .last_o  (m_last),
        .ready_i (m_ready),
        .count_o (buf_cnt)
    );

endmodule

// File: tb/tb_router_out_reader.sv
// Directed bench for router_out_reader with an upstream FIFO model and a
// downstream transfer monitor; counters use a 2-bit width so saturation is reachable.
`timescale 1ns/1ps
module tb_router_out_reader;
    import router_pkg::*;

    localparam int CW = 2;
`ifdef READER_PARITY_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          valid_out = 1'b0;
    logic          soft_reset = 1'b0;
    logic [7:0]    data_out = 8'h00;
    logic          m_ready = 1'b0;
    logic          read_en, m_valid, m_last, pkt_done, parity_err, pkt_abort;
    logic [7:0]    m_data;
    logic [CW-1:0] pkt_count, err_count;

    int checks = 0;
    int fails  = 0;

    logic [7:0] fifo[$];
    logic [7:0] got_d[$];
    logic       got_l[$];
    int         got_c[$];
    int         rd_c[$];
    int         cyc = 0;
    int         n_done = 0, n_perr = 0, n_err_done = 0, n_abort = 0;
    logic       rd_s = 1'b0;

    router_out_reader #(.CNT_W(CW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .valid_out  (valid_out),
        .soft_reset (soft_reset),
        .data_out   (data_out),
        .read_en    (read_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .pkt_done   (pkt_done),
        .parity_err (parity_err),
        .pkt_abort  (pkt_abort),
        .pkt_count  (pkt_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // Upstream FIFO: a read strobe seen in one cycle presents its byte in the next.
    initial begin
        forever begin
            @(negedge clk);
            rd_s = read_en;
            @(posedge clk);
            #1;
            if (rd_s && fifo.size() > 0) data_out = fifo.pop_front();
            valid_out = (fifo.size() > 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                got_d.push_back(m_data);
                got_l.push_back(m_last);
                got_c.push_back(cyc);
            end
            if (read_en) rd_c.push_back(cyc);
            if (pkt_done) begin
                n_done++;
                if (parity_err) n_err_done++;
            end
            if (parity_err) n_perr++;
            if (pkt_abort) n_abort++;
            cyc++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        got_d.delete();
        got_l.delete();
        got_c.delete();
        rd_c.delete();
        n_done = 0;
        n_perr = 0;
        n_err_done = 0;
        n_abort = 0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (n_done == 0 && k < limit) begin
            tick();
            k++;
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        m_ready = 1'b0;
        repeat (3) tick();
        checks++; if (read_en !== 1'b0) begin fails++; $display("FAIL reset_read_en got=%b exp=0", read_en); end
        checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_last !== 1'b0) begin fails++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
        checks++; if (m_data !== 8'h00) begin fails++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
        checks++; if (pkt_done !== 1'b0) begin fails++; $display("FAIL reset_pkt_done got=%b exp=0", pkt_done); end
        checks++; if (parity_err !== 1'b0) begin fails++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
        checks++; if (pkt_abort !== 1'b0) begin fails++; $display("FAIL reset_pkt_abort got=%b exp=0", pkt_abort); end
        checks++; if (pkt_count !== '0) begin fails++; $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
        checks++; if (err_count !== '0) begin fails++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] exp_d[4];
        exp_d[0] = 8'h0D; exp_d[1] = 8'h11; exp_d[2] = 8'h22; exp_d[3] = 8'h33;
        clear_mon();
        m_ready = 1'b1;
        fifo.push_back(8'h0D); fifo.push_back(8'h11); fifo.push_back(8'h22);
        fifo.push_back(8'h33); fifo.push_back(8'h0D);
        wait_done(60);
        checks++; if (n_done !== 1) begin fails++; $display("FAIL basic_pkt_done pulses=%0d exp=1", n_done); end
        checks++;
        if (got_d.size() != 4) begin
            fails++; $display("FAIL basic_len got=%0d bytes exp=4", got_d.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 3)) begin
                    fails++; $display("FAIL basic_byte%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], exp_d[i], (i == 3));
                end
            end
            checks++; if (got_c[3] - got_c[0] != 3) begin fails++; $display("FAIL basic_consecutive span=%0d exp=3", got_c[3] - got_c[0]); end
            checks++;
            if (rd_c.size() == 0 || got_c[0] - rd_c[0] != 2) begin
                fails++; $display("FAIL basic_latency reads=%0d first_xfer=%0d", rd_c.size(), got_c[0]);
            end
        end
        checks++; if (n_perr !== 0) begin fails++; $display("FAIL basic_parity_err pulses=%0d exp=0", n_perr); end
        checks++; if (pkt_count !== CW'(1)) begin fails++; $display("FAIL basic_pkt_count got=%0d exp=1", pkt_count); end
        checks++; if (err_count !== CW'(0)) begin fails++; $display("FAIL basic_err_count got=%0d exp=0", err_count); end
    endtask

    task automatic test_len0();
        clear_mon();
        m_ready = 1'b1;
        fifo.push_back(8'h01); fifo.push_back(8'h01);
        wait_done(40);
        checks++; if (n_done !== 1) begin fails++; $display("FAIL len0_pkt_done pulses=%0d exp=1", n_done); end
        checks++;
        if (got_d.size() != 1 || got_d[0] !== 8'h01 || got_l[0] !== 1'b1) begin
            fails++; $display("FAIL len0_stream got=%0d bytes first=%h exp=1 byte 01 last", got_d.size(), (got_d.size() > 0) ? got_d[0] : 8'hxx);
        end
        checks++; if (n_perr !== 0) begin fails++; $display("FAIL len0_parity_err pulses=%0d exp=0", n_perr); end
        checks++; if (pkt_count !== CW'(2)) begin fails++; $display("FAIL len0_pkt_count got=%0d exp=2", pkt_count); end
    endtask

    task automatic test_soft_reset();
        int k;
        logic [7:0] exp_d[4];
        exp_d[0] = 8'h0D; exp_d[1] = 8'h11; exp_d[2] = 8'h22; exp_d[3] = 8'h33;
        clear_mon();
        m_ready = 1'b1;
        fifo.push_back(8'h1D);
        for (int i = 0; i < 7; i++) fifo.push_back(8'h41 + 8'(i));
        fifo.push_back(8'h00);
        k = 0;
        while (got_d.size() < 3 && k < 60) begin tick(); k++; end
        checks++; if (got_d.size() < 3) begin fails++; $display("FAIL sr_stream_start got=%0d bytes exp>=3", got_d.size()); end
        checks++; if (dut.state_q !== PLD) begin fails++; $display("FAIL sr_state_before got=%0d exp=%0d", dut.state_q, PLD); end
        soft_reset = 1'b1;
        #1;
        checks++; if (read_en !== 1'b0) begin fails++; $display("FAIL sr_read_en got=%b exp=0", read_en); end
        fifo.delete();
        valid_out = 1'b0;
        tick();
        soft_reset = 1'b0;
        checks++; if (pkt_abort !== 1'b1) begin fails++; $display("FAIL sr_pkt_abort got=%b exp=1", pkt_abort); end
        checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL sr_m_valid got=%b exp=0", m_valid); end
        checks++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL sr_state got=%0d exp=%0d", dut.state_q, IDLE); end
        tick();
        checks++; if (pkt_abort !== 1'b0) begin fails++; $display("FAIL sr_abort_width got=%b exp=0", pkt_abort); end
        repeat (3) tick();
        checks++; if (n_abort !== 1) begin fails++; $display("FAIL sr_abort_pulses got=%0d exp=1", n_abort); end
        checks++; if (n_done !== 0) begin fails++; $display("FAIL sr_pkt_done pulses=%0d exp=0", n_done); end
        checks++; if (pkt_count !== CW'(2)) begin fails++; $display("FAIL sr_pkt_count got=%0d exp=2", pkt_count); end
        checks++; if (err_count !== CW'(0)) begin fails++; $display("FAIL sr_err_count got=%0d exp=0", err_count); end
        clear_mon();
        fifo.push_back(8'h0D); fifo.push_back(8'h11); fifo.push_back(8'h22);
        fifo.push_back(8'h33); fifo.push_back(8'h0D);
        wait_done(60);
        checks++;
        if (got_d.size() != 4 || got_d[0] !== exp_d[0] || got_d[1] !== exp_d[1] ||
            got_d[2] !== exp_d[2] || got_d[3] !== exp_d[3] || got_l[3] !== 1'b1) begin
            fails++; $display("FAIL sr_next_packet got=%0d bytes exp=0D 11 22 33", got_d.size());
        end
        checks++; if (n_done !== 1 || n_perr !== 0) begin fails++; $display("FAIL sr_next_done done=%0d perr=%0d exp=1/0", n_done, n_perr); end
        checks++; if (pkt_count !== CW'(3)) begin fails++; $display("FAIL sr_next_pkt_count got=%0d exp=3", pkt_count); end
    endtask

    task automatic test_parity_err();
        clear_mon();
        m_ready = 1'b1;
        fifo.push_back(8'h0D); fifo.push_back(8'h11); fifo.push_back(8'h22);
        fifo.push_back(8'h33); fifo.push_back(8'h00);
        wait_done(60);
        checks++; if (n_done !== 1) begin fails++; $display("FAIL perr_pkt_done pulses=%0d exp=1", n_done); end
        checks++; if (got_d.size() != 4) begin fails++; $display("FAIL perr_len got=%0d bytes exp=4", got_d.size()); end
        checks++; if (n_perr !== int'(CHK)) begin fails++; $display("FAIL perr_pulses got=%0d exp=%0d", n_perr, CHK); end
        checks++; if (n_err_done !== int'(CHK)) begin fails++; $display("FAIL perr_with_done got=%0d exp=%0d", n_err_done, CHK); end
        checks++; if (err_count !== CW'(CHK)) begin fails++; $display("FAIL perr_err_count got=%0d exp=%0d", err_count, CHK); end
        checks++; if (pkt_count !== CW'(3)) begin fails++; $display("FAIL perr_pkt_count_sat got=%0d exp=3", pkt_count); end
    endtask

    task automatic test_backpressure();
        int k;
        int late_rd;
        logic stable;
        logic [7:0] hold;
        logic [7:0] exp_d[6];
        exp_d[0] = 8'h15; exp_d[1] = 8'hA1; exp_d[2] = 8'hA2;
        exp_d[3] = 8'hA3; exp_d[4] = 8'hA4; exp_d[5] = 8'hA5;
        clear_mon();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) fifo.push_back(exp_d[i]);
        fifo.push_back(8'hB4);
        k = 0;
        while (got_d.size() < 2 && k < 60) begin tick(); k++; end
        m_ready = 1'b0;
        hold = m_data;
        stable = m_valid;
        late_rd = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (m_data !== hold || m_valid !== 1'b1) stable = 1'b0;
            if (i >= 2 && read_en) late_rd++;
        end
        checks++; if (stable !== 1'b1) begin fails++; $display("FAIL bp_hold_stable got=%b exp=1 held=%h", stable, hold); end
        checks++; if (late_rd != 0) begin fails++; $display("FAIL bp_read_stop got=%0d late reads exp=0", late_rd); end
        m_ready = 1'b1;
        wait_done(60);
        checks++;
        if (got_d.size() != 6) begin
            fails++; $display("FAIL bp_len got=%0d bytes exp=6", got_d.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 5)) begin
                    fails++; $display("FAIL bp_byte%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], exp_d[i], (i == 5));
                end
            end
        end
        checks++; if (n_done !== 1 || n_perr !== 0) begin fails++; $display("FAIL bp_done done=%0d perr=%0d exp=1/0", n_done, n_perr); end
        checks++; if (pkt_count !== CW'(3)) begin fails++; $display("FAIL bp_pkt_count_sat got=%0d exp=3", pkt_count); end
    endtask

    task automatic test_async_reset();
        int k;
        clear_mon();
        m_ready = 1'b0;
        fifo.push_back(8'h0D); fifo.push_back(8'h11); fifo.push_back(8'h22);
        fifo.push_back(8'h33); fifo.push_back(8'h0D);
        k = 0;
        while (m_valid !== 1'b1 && k < 30) begin tick(); k++; end
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h0D) begin fails++; $display("FAIL ar_preload got=%b/%h exp=1/0D", m_valid, m_data); end
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin fails++; $display("FAIL ar_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 8'h00) begin fails++; $display("FAIL ar_m_data got=%h exp=00", m_data); end
        checks++; if (read_en !== 1'b0) begin fails++; $display("FAIL ar_read_en got=%b exp=0", read_en); end
        checks++; if (pkt_count !== CW'(0)) begin fails++; $display("FAIL ar_pkt_count got=%0d exp=0", pkt_count); end
        checks++; if (err_count !== CW'(0)) begin fails++; $display("FAIL ar_err_count got=%0d exp=0", err_count); end
        checks++; if (dut.state_q !== IDLE) begin fails++; $display("FAIL ar_state got=%0d exp=%0d", dut.state_q, IDLE); end
        fifo.delete();
        valid_out = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        clear_mon();
        m_ready = 1'b1;
        fifo.push_back(8'h01); fifo.push_back(8'h01);
        wait_done(40);
        checks++;
        if (got_d.size() != 1 || got_d[0] !== 8'h01 || n_done !== 1) begin
            fails++; $display("FAIL ar_resume got=%0d bytes done=%0d exp=1/1", got_d.size(), n_done);
        end
        checks++; if (pkt_count !== CW'(1)) begin fails++; $display("FAIL ar_resume_count got=%0d exp=1", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_soft_reset();
        test_parity_err();
        test_backpressure();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
